rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rom_arbiter_rr_pick.sv | 41 ++++
 rtl/rom_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rom_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared defaults, FSM state encoding and index helpers for the ROM arbiter.
// The lock feature is enabled by defining ROM_ARBITER_LOCK_EN.
package rom_arb_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_LOCK_MAX = 4;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Next index in round-robin order, wrapping at n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or above the
// pointer (wrapping) wins; returns a one-hot winner, its index and a valid flag.
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_valid
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a value held over and no latch is inferred.
    always_comb begin
        o_gnt    = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(i_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!o_valid && i_req[cand_idx]) begin
                o_valid         = 1'b1;
                o_gnt[cand_idx] = 1'b1;
                o_idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM among NUM_REQ readers.
// Define ROM_ARBITER_LOCK_EN to enable the OPEN/LOCKED burst-lock FSM.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ-1:0]        i_lock,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [DATA_W-1:0]         i_rom_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_valid;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_gnt   (rr_gnt),
        .o_idx   (rr_idx),
        .o_valid (rr_valid)
    );

`ifdef ROM_ARBITER_LOCK_EN

    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  own_q, own_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              hold_own;

    // A locked owner that drops its request releases the lock this same cycle.
    assign hold_own = (state_q == ST_LOCKED) && i_req[own_q];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_OPEN;
            own_q   <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            lcnt_q  <= lcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        lcnt_d  = lcnt_q;
        ptr_d   = ptr_q;
        if (hold_own) begin
            lcnt_d = lcnt_q + 1'b1;
            if (!i_lock[own_q] || lcnt_d == LCNT_W'(LOCK_MAX)) begin
                state_d = ST_OPEN;
                lcnt_d  = '0;
                ptr_d   = PTR_W'(wrap_inc(int'(own_q), NUM_REQ));
            end
        end else begin
            state_d = ST_OPEN;
            lcnt_d  = '0;
            if (rr_valid) begin
                ptr_d = PTR_W'(wrap_inc(int'(rr_idx), NUM_REQ));
                if (i_lock[rr_idx]) begin
                    state_d = ST_LOCKED;
                    own_d   = rr_idx;
                    lcnt_d  = LCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (i_rst_n) begin
            if (hold_own) begin
                gnt[own_q] = 1'b1;
                gnt_idx    = own_q;
                gnt_valid  = 1'b1;
            end else begin
                gnt       = rr_gnt;
                gnt_idx   = rr_idx;
                gnt_valid = rr_valid;
            end
        end
    end

`else

    // Lock hints and the lock cap have no effect in the pure round-robin build.
    logic unused_lock;
    assign unused_lock = ^{i_lock, 4'(LOCK_MAX)};

    always_comb begin
        ptr_d = ptr_q;
        if (rr_valid) begin
            ptr_d = PTR_W'(wrap_inc(int'(rr_idx), NUM_REQ));
        end
    end

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (i_rst_n) begin
            gnt       = rr_gnt;
            gnt_idx   = rr_idx;
            gnt_valid = rr_valid;
        end
    end

`endif

    assign rvalid_d = gnt;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        o_rom_addr = '0;
        if (gnt_valid) begin
            o_rom_addr = i_addr[gnt_idx*ADDR_W +: ADDR_W];
        end
    end

    assign o_gnt    = gnt;
    assign o_rvalid = rvalid_q;
    assign o_rdata  = i_rom_data;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random traffic
// against a behavioural model; lock scenarios apply when ROM_ARBITER_LOCK_EN is defined.
module tb_rom_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int LM = 4;
`ifdef ROM_ARBITER_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    lock;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_data;

    logic [DW-1:0]   rom_mem [256];

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state.
    int           m_ptr;
    bit           m_locked;
    int           m_owner;
    int           m_run;
    logic [N-1:0] prev_gnt;
    logic [AW-1:0] prev_addr;

    rom_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .LOCK_MAX (LM)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_addr     (addr),
        .i_lock     (lock),
        .o_gnt      (gnt),
        .o_rvalid   (rvalid),
        .o_rdata    (rdata),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        addr[i*AW +: AW] = a;
    endtask

    task automatic model_reset();
        m_ptr     = 0;
        m_locked  = 1'b0;
        m_owner   = 0;
        m_run     = 0;
        prev_gnt  = '0;
        prev_addr = '0;
    endtask

    function automatic int exp_winner();
        if (LOCK_EN && m_locked && req[m_owner]) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input int w);
        if (LOCK_EN && m_locked && req[m_owner]) begin
            m_run++;
            if (!lock[m_owner] || m_run == LM) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
        end else begin
            m_locked = 1'b0;
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                if (LOCK_EN && lock[w]) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_run    = 1;
                end
            end
        end
    endtask

    // One clock: inputs already driven; sample on the falling edge, check, advance.
    task automatic cycle(output int w, output logic [N-1:0] g_obs);
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        @(negedge clk);
        g_obs = gnt;
        if (!rst_n) begin
            w = -1;
            check("rst_gnt", gnt, 0);
            check("rst_rom_addr", rom_addr, 0);
            check("rst_rvalid", rvalid, 0);
            prev_gnt = '0;
        end else begin
            w  = exp_winner();
            eg = (w >= 0) ? N'(1 << w) : '0;
            ea = (w >= 0) ? addr[w*AW +: AW] : '0;
            check("gnt", gnt, eg);
            check("rom_addr", rom_addr, ea);
            check("rvalid", rvalid, prev_gnt);
            if (prev_gnt != '0) check("rdata", rdata, rom_mem[prev_addr]);
            model_update(w);
            prev_gnt  = eg;
            prev_addr = ea;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           w;
        logic [N-1:0] g;
        logic [N-1:0] g_prev;
        logic [N-1:0] pending;
        logic [N-1:0] lock_seq [6];

        for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
        rom_mem[8'h10] = 16'hBEEF;
        rst_n = 1'b0;
        req   = '1;
        lock  = '0;
        for (int i = 0; i < N; i++) set_addr(i, AW'($urandom));
        model_reset();

        // Reset holds everything idle even with all requesters active.
        repeat (2) cycle(w, g);
        rst_n = 1'b1;
        model_reset();

        // First edge after reset grants requester 0, then strict rotation.
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < N; j++) set_addr(j, AW'($urandom));
            cycle(w, g);
        end

        // Single requester 2 reading 0x10, then idle cycles.
        req = 4'b0100;
        set_addr(2, 8'h10);
        cycle(w, g);
        check("single_gnt", g, 4'b0100);
        req = '0;
        cycle(w, g);
        cycle(w, g);

        // Reset pulse right after a grant drops the pending rvalid.
        req = '1;
        cycle(w, g);
        cycle(w, g);
        rst_n = 1'b0;
        cycle(w, g);
        rst_n = 1'b1;
        model_reset();
        cycle(w, g);
        check("post_rst_gnt", g, 4'b0001);

`ifdef ROM_ARBITER_LOCK_EN
        // Lock on requester 1 with 0 and 3 also pending: capped at LOCK_MAX.
        req = 4'b0001;
        cycle(w, g);
        lock_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
        req  = 4'b1011;
        lock = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            cycle(w, g);
            check("lock_seq", g, lock_seq[i]);
        end
        // Owner 2 drops its request while locked: requester 0 wins at once.
        req  = 4'b0100;
        lock = 4'b0100;
        cycle(w, g);
        check("lock_own2", g, 4'b0100);
        req  = 4'b0001;
        lock = '0;
        cycle(w, g);
        check("lock_release", g, 4'b0001);
        cycle(w, g);
`else
        // Lock hints ignored: two requesters alternate strictly.
        req  = 4'b0011;
        lock = '1;
        cycle(w, g);
        g_prev = g;
        for (int i = 0; i < 5; i++) begin
            cycle(w, g);
            check("alternate", g, (g_prev == 4'b0001) ? 4'b0010 : 4'b0001);
            g_prev = g;
        end
`endif

        // Random traffic; a requester holds request and address until granted.
        pending = '0;
        lock    = '0;
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!pending[j] && ($urandom_range(0, 1) == 1)) begin
                    pending[j] = 1'b1;
                    set_addr(j, AW'($urandom));
                end
            end
            req  = pending;
            lock = N'($urandom);
            if (i == 200) rst_n = 1'b0;
            cycle(w, g);
            if (i == 200) begin
                rst_n = 1'b1;
                model_reset();
            end
            if (w >= 0) pending[w] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
